// File: rtl/mem_arbiter_2to1.sv
// mem_arbiter_2to1
// Round-robin arbiter between the I-cache (line reads only) and the D-cache
// (line reads and writes) in front of a single main-memory port. One line
// transaction of BEATS beats is in flight at a time. Response beats go only
// to the cache that owns the transaction.
//
// Handshake semantics: a transfer happens on a cycle where valid && ready are
// both high at the rising edge. A valid is never qualified by its own ready.
// The req_ready seen by a cache has two roles. In IDLE it is the acceptance
// of that cache's request. Later it is a one-cycle line-complete strobe on
// the final beat.
//
// Ports:
//   clk, reset                   clock, synchronous active-low reset
//   ic_req_*                     I-cache line read request
//   ic_resp_*                    read beats to the I-cache
//   dc_req_* (addr/rw)           D-cache request
//   dc_req_data_*                D-cache write beats
//   dc_resp_*                    read beats to the D-cache
//   mem_req_*                    memory request and write-beat channel
//   mem_resp_*                   memory read beats
//   dbg_state, dbg_beat_cnt      FSM state and beat counter, for observation
`timescale 1ns/1ps
module mem_arbiter_2to1 #(
  parameter int ADDR_BITS = 28,
  parameter int DATA_BITS = 128,
  parameter int MASK_BITS = 16,
  parameter int BEATS     = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 ic_req_valid,
  output logic                 ic_req_ready,
  input  logic [ADDR_BITS-1:0] ic_req_addr,
  output logic                 ic_resp_valid,
  output logic [DATA_BITS-1:0] ic_resp_data,
  input  logic                 dc_req_valid,
  output logic                 dc_req_ready,
  input  logic [ADDR_BITS-1:0] dc_req_addr,
  input  logic                 dc_req_rw,
  input  logic                 dc_req_data_valid,
  output logic                 dc_req_data_ready,
  input  logic [DATA_BITS-1:0] dc_req_data_bits,
  input  logic [MASK_BITS-1:0] dc_req_data_mask,
  output logic                 dc_resp_valid,
  output logic [DATA_BITS-1:0] dc_resp_data,
  output logic                 mem_req_valid,
  input  logic                 mem_req_ready,
  output logic [ADDR_BITS-1:0] mem_req_addr,
  output logic                 mem_req_rw,
  output logic                 mem_req_data_valid,
  input  logic                 mem_req_data_ready,
  output logic [DATA_BITS-1:0] mem_req_data_bits,
  output logic [MASK_BITS-1:0] mem_req_data_mask,
  input  logic                 mem_resp_valid,
  input  logic [DATA_BITS-1:0] mem_resp_data,
  output logic [1:0]           dbg_state,
  output logic [1:0]           dbg_beat_cnt
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    IC_RD = 2'd1,
    DC_RD = 2'd2,
    DC_WR = 2'd3
  } state_t;

  state_t     state, state_nxt;
  logic [1:0] beat_cnt, beat_cnt_nxt;
  logic       last_grant_dc;   // 1: the D-cache won the previous grant
  logic       grant_ic, grant_dc, accept, last_beat, rd_beat, wr_beat;

  // Arbitration is only meaningful in IDLE and outside reset. On a tie the
  // client that did not win last time gets the grant.
  always_comb begin
    grant_ic = 1'b0;
    grant_dc = 1'b0;
    if (reset && state == IDLE) begin
      if (ic_req_valid && dc_req_valid) begin
        grant_ic = last_grant_dc;
        grant_dc = !last_grant_dc;
      end else begin
        grant_ic = ic_req_valid;
        grant_dc = dc_req_valid;
      end
    end
  end

  assign accept    = (grant_ic | grant_dc) & mem_req_ready;
  assign last_beat = (beat_cnt == 2'(BEATS - 1));
  assign rd_beat   = reset & mem_resp_valid & ((state == IC_RD) || (state == DC_RD));
  assign wr_beat   = reset & (state == DC_WR) & dc_req_data_valid & mem_req_data_ready;

  // State register
  always_ff @(posedge clk) begin
    if (!reset) begin
      state         <= IDLE;
      beat_cnt      <= 2'd0;
      last_grant_dc <= 1'b1;   // I-cache wins the first tie after reset
    end else begin
      state    <= state_nxt;
      beat_cnt <= beat_cnt_nxt;
      if (accept) last_grant_dc <= grant_dc;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt    = state;
    beat_cnt_nxt = beat_cnt;
    case (state)
      IDLE: begin
        if (accept) begin
          beat_cnt_nxt = 2'd0;
          if (grant_ic)       state_nxt = IC_RD;
          else if (dc_req_rw) state_nxt = DC_WR;
          else                state_nxt = DC_RD;
        end
      end
      IC_RD, DC_RD: begin
        if (rd_beat) begin
          if (last_beat) begin
            state_nxt    = IDLE;
            beat_cnt_nxt = 2'd0;
          end else begin
            beat_cnt_nxt = beat_cnt + 2'd1;
          end
        end
      end
      DC_WR: begin
        if (wr_beat) begin
          if (last_beat) begin
            state_nxt    = IDLE;
            beat_cnt_nxt = 2'd0;
          end else begin
            beat_cnt_nxt = beat_cnt + 2'd1;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Output logic. Everything is forced low while reset is asserted, so a
  // transaction that is being aborted forwards no more beats.
  always_comb begin
    ic_req_ready       = 1'b0;
    ic_resp_valid      = 1'b0;
    ic_resp_data       = '0;
    dc_req_ready       = 1'b0;
    dc_req_data_ready  = 1'b0;
    dc_resp_valid      = 1'b0;
    dc_resp_data       = '0;
    mem_req_valid      = 1'b0;
    mem_req_addr       = '0;
    mem_req_rw         = 1'b0;
    mem_req_data_valid = 1'b0;
    mem_req_data_bits  = '0;
    mem_req_data_mask  = '0;
    if (reset) begin
      case (state)
        IDLE: begin
          if (grant_ic) begin
            mem_req_valid = 1'b1;
            mem_req_addr  = ic_req_addr;
            mem_req_rw    = 1'b0;
            ic_req_ready  = mem_req_ready;
          end else if (grant_dc) begin
            mem_req_valid = 1'b1;
            mem_req_addr  = dc_req_addr;
            mem_req_rw    = dc_req_rw;
            dc_req_ready  = mem_req_ready;
          end
        end
        IC_RD: begin
          ic_resp_valid = mem_resp_valid;
          ic_resp_data  = mem_resp_valid ? mem_resp_data : '0;
          ic_req_ready  = rd_beat & last_beat;
        end
        DC_RD: begin
          dc_resp_valid = mem_resp_valid;
          dc_resp_data  = mem_resp_valid ? mem_resp_data : '0;
          dc_req_ready  = rd_beat & last_beat;
        end
        DC_WR: begin
          mem_req_data_valid = dc_req_data_valid;
          mem_req_data_bits  = dc_req_data_bits;
          mem_req_data_mask  = dc_req_data_mask;
          dc_req_data_ready  = mem_req_data_ready;
          dc_req_ready       = wr_beat & last_beat;
        end
        default: ;
      endcase
    end
  end

  assign dbg_state    = state;
  assign dbg_beat_cnt = beat_cnt;

endmodule

// File: tb/tb_mem_arbiter_2to1.sv
`timescale 1ns/1ps
module tb_mem_arbiter_2to1;
  localparam int AW = 28;
  localparam int DW = 128;
  localparam int MW = 16;
  localparam logic [1:0] S_IDLE = 2'd0, S_IC_RD = 2'd1, S_DC_RD = 2'd2, S_DC_WR = 2'd3;

  logic          clk = 1'b0;
  logic          reset;
  logic          ic_req_valid, ic_req_ready;
  logic [AW-1:0] ic_req_addr;
  logic          ic_resp_valid;
  logic [DW-1:0] ic_resp_data;
  logic          dc_req_valid, dc_req_ready;
  logic [AW-1:0] dc_req_addr;
  logic          dc_req_rw;
  logic          dc_req_data_valid, dc_req_data_ready;
  logic [DW-1:0] dc_req_data_bits;
  logic [MW-1:0] dc_req_data_mask;
  logic          dc_resp_valid;
  logic [DW-1:0] dc_resp_data;
  logic          mem_req_valid, mem_req_ready;
  logic [AW-1:0] mem_req_addr;
  logic          mem_req_rw;
  logic          mem_req_data_valid, mem_req_data_ready;
  logic [DW-1:0] mem_req_data_bits;
  logic [MW-1:0] mem_req_data_mask;
  logic          mem_resp_valid;
  logic [DW-1:0] mem_resp_data;
  logic [1:0]    dbg_state, dbg_beat_cnt;

  logic [DW-1:0] exp_q[$];
  int n_total = 0;
  int n_bad   = 0;

  mem_arbiter_2to1 dut (
    .clk(clk), .reset(reset),
    .ic_req_valid(ic_req_valid), .ic_req_ready(ic_req_ready), .ic_req_addr(ic_req_addr),
    .ic_resp_valid(ic_resp_valid), .ic_resp_data(ic_resp_data),
    .dc_req_valid(dc_req_valid), .dc_req_ready(dc_req_ready), .dc_req_addr(dc_req_addr),
    .dc_req_rw(dc_req_rw), .dc_req_data_valid(dc_req_data_valid),
    .dc_req_data_ready(dc_req_data_ready), .dc_req_data_bits(dc_req_data_bits),
    .dc_req_data_mask(dc_req_data_mask), .dc_resp_valid(dc_resp_valid),
    .dc_resp_data(dc_resp_data), .mem_req_valid(mem_req_valid),
    .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr), .mem_req_rw(mem_req_rw),
    .mem_req_data_valid(mem_req_data_valid), .mem_req_data_ready(mem_req_data_ready),
    .mem_req_data_bits(mem_req_data_bits), .mem_req_data_mask(mem_req_data_mask),
    .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data),
    .dbg_state(dbg_state), .dbg_beat_cnt(dbg_beat_cnt)
  );

  // Clock / reset
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Inputs are driven at the falling edge; outputs are checked 1ns later.
  task automatic next_cyc();
    @(negedge clk);
  endtask

  task automatic clear_inputs();
    ic_req_valid = 0; ic_req_addr = '0;
    dc_req_valid = 0; dc_req_addr = '0; dc_req_rw = 0;
    dc_req_data_valid = 0; dc_req_data_bits = '0; dc_req_data_mask = '0;
    mem_req_ready = 0; mem_req_data_ready = 0;
    mem_resp_valid = 0; mem_resp_data = '0;
  endtask

  // One I-cache read beat; expected data comes from the scoreboard queue.
  task automatic ic_beat(input logic [DW-1:0] d, input logic last);
    logic [DW-1:0] e;
    mem_resp_valid = 1; mem_resp_data = d;
    #1;
    e = (exp_q.size() > 0) ? exp_q.pop_front() : '1;
    check_eq("ic_beat_valid", ic_resp_valid, 1'b1);
    check_eq("ic_beat_data", ic_resp_data, e);
    check_eq("ic_beat_dc_valid", dc_resp_valid, 1'b0);
    check_eq("ic_beat_done", ic_req_ready, last);
    next_cyc();
    mem_resp_valid = 0;
  endtask

  initial begin
    reset = 0;
    clear_inputs();
    next_cyc(); next_cyc();
    #1;
    check_eq("rst_state", dbg_state, S_IDLE);
    check_eq("rst_cnt", dbg_beat_cnt, 2'd0);
    check_eq("rst_mem_valid", mem_req_valid, 1'b0);
    check_eq("rst_ic_ready", ic_req_ready, 1'b0);
    next_cyc();
    reset = 1;

    // ---- I-cache line read with a gap after beat 1 ----
    ic_req_valid = 1; ic_req_addr = 28'h0000123; mem_req_ready = 1;
    #1;
    check_eq("ic_acc_valid", mem_req_valid, 1'b1);
    check_eq("ic_acc_addr", mem_req_addr, 28'h0000123);
    check_eq("ic_acc_rw", mem_req_rw, 1'b0);
    check_eq("ic_acc_ready", ic_req_ready, 1'b1);
    check_eq("ic_acc_dc_ready", dc_req_ready, 1'b0);
    next_cyc();
    ic_req_valid = 0; ic_req_addr = '0; mem_req_ready = 0;
    #1;
    check_eq("ic_rd_state", dbg_state, S_IC_RD);
    check_eq("ic_rd_mem_valid", mem_req_valid, 1'b0);
    for (int i = 0; i < 4; i++) exp_q.push_back(128'hA0 + 128'(i));
    for (int i = 0; i < 4; i++) begin
      ic_beat(128'hA0 + 128'(i), i == 3);
      if (i == 1) begin
        for (int g = 0; g < 2; g++) begin
          #1;
          check_eq("ic_gap_valid", ic_resp_valid, 1'b0);
          check_eq("ic_gap_done", ic_req_ready, 1'b0);
          next_cyc();
        end
      end
    end
    #1;
    check_eq("ic_end_state", dbg_state, S_IDLE);

    // ---- Spurious response beat in IDLE ----
    mem_resp_valid = 1; mem_resp_data = 128'hDEAD;
    #1;
    check_eq("idle_spur_ic", ic_resp_valid, 1'b0);
    check_eq("idle_spur_dc", dc_resp_valid, 1'b0);
    next_cyc();
    mem_resp_valid = 0;
    #1;
    check_eq("idle_spur_cnt", dbg_beat_cnt, 2'd0);
    check_eq("idle_spur_state", dbg_state, S_IDLE);

    // ---- D-cache line write, stall on beat 2, spurious resp during stall ----
    dc_req_valid = 1; dc_req_rw = 1; dc_req_addr = 28'h0FFFFFF; mem_req_ready = 1;
    #1;
    check_eq("dw_acc_addr", mem_req_addr, 28'h0FFFFFF);
    check_eq("dw_acc_rw", mem_req_rw, 1'b1);
    check_eq("dw_acc_ready", dc_req_ready, 1'b1);
    check_eq("dw_acc_data_valid", mem_req_data_valid, 1'b0);
    next_cyc();
    dc_req_valid = 0; mem_req_ready = 0;
    for (int i = 0; i < 4; i++) begin
      dc_req_data_valid = 1; dc_req_data_bits = 128'hB0 + 128'(i); dc_req_data_mask = 16'hFFFF;
      if (i == 2) begin
        for (int s = 0; s < 3; s++) begin
          mem_req_data_ready = 0;
          mem_resp_valid = (s == 1);
          #1;
          check_eq("dw_stall_dready", dc_req_data_ready, 1'b0);
          check_eq("dw_stall_dvalid", mem_req_data_valid, 1'b1);
          check_eq("dw_stall_done", dc_req_ready, 1'b0);
          check_eq("dw_spur_ic", ic_resp_valid, 1'b0);
          check_eq("dw_spur_dc", dc_resp_valid, 1'b0);
          next_cyc();
          mem_resp_valid = 0;
          #1;
          check_eq("dw_stall_cnt", dbg_beat_cnt, 2'd2);
        end
      end
      mem_req_data_ready = 1;
      #1;
      check_eq("dw_beat_dvalid", mem_req_data_valid, 1'b1);
      check_eq("dw_beat_bits", mem_req_data_bits, 128'hB0 + 128'(i));
      check_eq("dw_beat_mask", mem_req_data_mask, 16'hFFFF);
      check_eq("dw_beat_dready", dc_req_data_ready, 1'b1);
      check_eq("dw_beat_done", dc_req_ready, i == 3);
      check_eq("dw_beat_resp", ic_resp_valid | dc_resp_valid, 1'b0);
      next_cyc();
    end
    // Data valid held high in IDLE must not leak through.
    #1;
    check_eq("dw_end_state", dbg_state, S_IDLE);
    check_eq("dw_end_dvalid", mem_req_data_valid, 1'b0);
    check_eq("dw_end_dready", dc_req_data_ready, 1'b0);
    next_cyc();
    clear_inputs();

    // ---- Round robin from reset with both held valid ----
    reset = 0;
    next_cyc();
    reset = 1;
    ic_req_valid = 1; ic_req_addr = 28'h0000111;
    dc_req_valid = 1; dc_req_addr = 28'h0000222; dc_req_rw = 0;
    mem_req_ready = 1;
    for (int t = 0; t < 4; t++) begin
      logic exp_ic;
      exp_ic = (t % 2 == 0);
      #1;
      check_eq("rr_state", dbg_state, S_IDLE);
      check_eq("rr_ic_ready", ic_req_ready, exp_ic);
      check_eq("rr_dc_ready", dc_req_ready, !exp_ic);
      check_eq("rr_addr", mem_req_addr, exp_ic ? 28'h0000111 : 28'h0000222);
      next_cyc();
      for (int b = 0; b < 4; b++) begin
        mem_resp_valid = 1; mem_resp_data = 128'(t * 16 + b);
        #1;
        check_eq("rr_wait", mem_req_valid, 1'b0);
        check_eq("rr_ic_rv", ic_resp_valid, exp_ic);
        check_eq("rr_dc_rv", dc_resp_valid, !exp_ic);
        check_eq("rr_data", exp_ic ? ic_resp_data : dc_resp_data, 128'(t * 16 + b));
        next_cyc();
        mem_resp_valid = 0;
      end
    end
    ic_req_valid = 0; dc_req_valid = 0;

    // ---- Memory not ready for 5 cycles ----
    ic_req_valid = 1; ic_req_addr = 28'h0000345; mem_req_ready = 0;
    for (int c = 0; c < 5; c++) begin
      #1;
      check_eq("nr_ic_ready", ic_req_ready, 1'b0);
      check_eq("nr_state", dbg_state, S_IDLE);
      check_eq("nr_mem_valid", mem_req_valid, 1'b1);
      next_cyc();
    end
    mem_req_ready = 1;
    #1;
    check_eq("nr_acc_ready", ic_req_ready, 1'b1);
    next_cyc();
    ic_req_valid = 0; mem_req_ready = 0;
    #1;
    check_eq("nr_acc_state", dbg_state, S_IC_RD);
    for (int i = 0; i < 4; i++) exp_q.push_back(128'hC0 + 128'(i));
    for (int i = 0; i < 4; i++) ic_beat(128'hC0 + 128'(i), i == 3);

    // ---- Reset after 2 of 4 D-cache read beats ----
    dc_req_valid = 1; dc_req_rw = 0; dc_req_addr = 28'h0000456; mem_req_ready = 1;
    #1;
    check_eq("ab_acc_ready", dc_req_ready, 1'b1);
    next_cyc();
    dc_req_valid = 0; mem_req_ready = 0;
    for (int b = 0; b < 2; b++) begin
      mem_resp_valid = 1; mem_resp_data = 128'hD0 + 128'(b);
      #1;
      check_eq("ab_beat_valid", dc_resp_valid, 1'b1);
      check_eq("ab_beat_data", dc_resp_data, 128'hD0 + 128'(b));
      next_cyc();
    end
    #1;
    check_eq("ab_pre_state", dbg_state, S_DC_RD);
    check_eq("ab_pre_cnt", dbg_beat_cnt, 2'd2);
    reset = 0; mem_resp_valid = 1; mem_resp_data = 128'hD2;
    #1;
    check_eq("ab_rst_dc_rv", dc_resp_valid, 1'b0);
    next_cyc();
    reset = 1; mem_resp_valid = 0;
    #1;
    check_eq("ab_post_state", dbg_state, S_IDLE);
    check_eq("ab_post_cnt", dbg_beat_cnt, 2'd0);
    check_eq("ab_post_mem_valid", mem_req_valid, 1'b0);
    check_eq("ab_post_dc_rv", dc_resp_valid, 1'b0);
    check_eq("ab_post_dc_ready", dc_req_ready, 1'b0);
    next_cyc();
    ic_req_valid = 1; ic_req_addr = 28'h0000777;
    dc_req_valid = 1; dc_req_addr = 28'h0000888; mem_req_ready = 1;
    #1;
    check_eq("ab_tie_ic", ic_req_ready, 1'b1);
    check_eq("ab_tie_dc", dc_req_ready, 1'b0);
    check_eq("ab_tie_addr", mem_req_addr, 28'h0000777);
    next_cyc();
    clear_inputs();

    check_eq("scoreboard_empty", 128'(exp_q.size()), 128'd0);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  // Absolute time limit so the bench always ends.
  initial begin
    #200000;
    $display("FAIL timeout: got=running exp=finished");
    $fatal(1);
  end

endmodule
